// File: rtl/ring_decoder_checker_pkg.sv
// Shared types and helpers for one-hot ring consumers (package ring_pkg).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ring_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } ring_state_t;

  localparam int RING_WIDTH_DEF     = 4;
  localparam int RING_LOCK_CNT_DEF  = 3;
  localparam int RING_ERR_CNT_W_DEF = 8;

  // Position that follows idx on a ring of the given width.
  function automatic int ring_next_index(input int idx, input int width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ring_decoder_checker_if.sv
// Bundle between a ring word source and the ring decoder/checker.
// Latency: n/a (wiring only).
// Backpressure: none; the checker samples every edge on which ring_valid is high.
// Ports: ring_in/ring_valid from the source; index_out, index_valid, locked,
//        onehot_err, seq_err, err_count back from the checker.
interface ring_decoder_checker_if
  import ring_pkg::*;
#(
  parameter int WIDTH     = RING_WIDTH_DEF,
  parameter int ERR_CNT_W = RING_ERR_CNT_W_DEF
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0]     ring_in;
  logic                 ring_valid;
  logic [IW-1:0]        index_out;
  logic                 index_valid;
  logic                 locked;
  logic                 onehot_err;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_count;

  // Source side drives the ring word and observes the checker results.
  modport master (
    output ring_in, ring_valid,
    input  index_out, index_valid, locked, onehot_err, seq_err, err_count
  );

  // Checker side.
  modport slave (
    input  ring_in, ring_valid,
    output index_out, index_valid, locked, onehot_err, seq_err, err_count
  );

endinterface

// File: rtl/ring_decoder_checker_onehot_to_index.sv
// One-hot word to binary index decoder with a legality flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_word (WIDTH) in; o_index (IW) and o_legal (exactly one bit set) out.
module onehot_to_index #(
  parameter int WIDTH = 4,
  localparam int IW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_word,
  output logic [IW-1:0]    o_index,
  output logic             o_legal
);

  // OR of set-bit positions; only meaningful when o_legal is high.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_word[i]) o_index = o_index | IW'(i);
    end
  end

  // Non-zero and a power of two.
  assign o_legal = (i_word != '0) && ((i_word & (i_word - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_decoder_checker.sv
// Ring word decoder and rotation-order checker with lock detection and error count.
// Latency: 1 cycle; every output reflects the sample taken on the previous edge.
// Backpressure: none; a sample is taken on every edge with ring_valid high.
// Ports: clock, reset (async active-low), rif (slave: ring_in/ring_valid in,
//        index_out/index_valid/locked/onehot_err/seq_err/err_count out).
// Optional: RING_HOLD_LOCK_EN lets LOCKED ride through one isolated error.
module ring_decoder_checker
  import ring_pkg::*;
#(
  parameter int WIDTH     = RING_WIDTH_DEF,
  parameter int LOCK_CNT  = RING_LOCK_CNT_DEF,
  parameter int ERR_CNT_W = RING_ERR_CNT_W_DEF
) (
  input logic                   clock,
  input logic                   reset,
  ring_decoder_checker_if.slave rif
);

  localparam int IW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_CNT + 1);

  ring_state_t          r_state, w_state_nxt;
  logic [IW-1:0]        r_index, w_index_nxt;
  logic [IW-1:0]        r_expected, w_expected_nxt;
  logic [MW-1:0]        r_match, w_match_nxt, w_match_inc;
  logic [IW-1:0]        w_pos;
  logic                 w_legal, w_hit;
  logic                 r_index_valid, w_index_valid_nxt;
  logic                 r_locked;
  logic                 r_onehot_err, w_onehot_err_nxt;
  logic                 r_seq_err, w_seq_err_nxt;
  logic [ERR_CNT_W-1:0] r_err_count;
`ifdef RING_HOLD_LOCK_EN
  // Set after one tolerated error in LOCKED; a second consecutive error drops lock.
  logic                 r_miss, w_miss_nxt;
`endif

  onehot_to_index #(.WIDTH(WIDTH)) u_dec (
    .i_word  (rif.ring_in),
    .o_index (w_pos),
    .o_legal (w_legal)
  );

  assign w_hit       = (w_pos == r_expected);
  assign w_match_inc = r_match + MW'(1);

  always_comb begin
    w_state_nxt       = r_state;
    w_index_nxt       = r_index;
    w_expected_nxt    = r_expected;
    w_match_nxt       = r_match;
    w_index_valid_nxt = 1'b0;
    w_onehot_err_nxt  = 1'b0;
    w_seq_err_nxt     = 1'b0;
`ifdef RING_HOLD_LOCK_EN
    w_miss_nxt        = r_miss;
`endif
    if (rif.ring_valid) begin
      if (!w_legal) begin
        w_onehot_err_nxt = 1'b1;
        w_match_nxt      = '0;
        if (r_state == LOCKED) begin
`ifdef RING_HOLD_LOCK_EN
          if (!r_miss) begin
            w_miss_nxt  = 1'b1;
          end else begin
            w_state_nxt = UNLOCKED;
            w_miss_nxt  = 1'b0;
          end
`else
          w_state_nxt = UNLOCKED;
`endif
        end else begin
          w_state_nxt = UNLOCKED;
        end
      end else begin
        w_index_nxt       = w_pos;
        w_index_valid_nxt = 1'b1;
        // Every legal word re-anchors the expectation, hit or not.
        w_expected_nxt    = IW'(ring_next_index(int'(w_pos), WIDTH));
        case (r_state)
          UNLOCKED: begin
            w_state_nxt = LOCKING;
            w_match_nxt = '0;
          end
          LOCKING: begin
            if (w_hit) begin
              if (w_match_inc == MW'(LOCK_CNT)) begin
                w_state_nxt = LOCKED;
                w_match_nxt = '0;
              end else begin
                w_match_nxt = w_match_inc;
              end
            end else begin
              w_match_nxt = '0;
            end
          end
          LOCKED: begin
            if (w_hit) begin
`ifdef RING_HOLD_LOCK_EN
              w_miss_nxt = 1'b0;
`endif
            end else begin
              w_seq_err_nxt = 1'b1;
              w_match_nxt   = '0;
`ifdef RING_HOLD_LOCK_EN
              if (!r_miss) begin
                w_miss_nxt  = 1'b1;
              end else begin
                w_state_nxt = LOCKING;
                w_miss_nxt  = 1'b0;
              end
`else
              w_state_nxt = LOCKING;
`endif
            end
          end
          default: begin
            w_state_nxt = UNLOCKED;
            w_match_nxt = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= UNLOCKED;
      r_index       <= '0;
      r_expected    <= '0;
      r_match       <= '0;
      r_index_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_onehot_err  <= 1'b0;
      r_seq_err     <= 1'b0;
      r_err_count   <= '0;
`ifdef RING_HOLD_LOCK_EN
      r_miss        <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_index       <= w_index_nxt;
      r_expected    <= w_expected_nxt;
      r_match       <= w_match_nxt;
      r_index_valid <= w_index_valid_nxt;
      r_locked      <= (w_state_nxt == LOCKED);
      r_onehot_err  <= w_onehot_err_nxt;
      r_seq_err     <= w_seq_err_nxt;
      // The two error pulses are exclusive, so at most +1 per cycle.
      if ((w_onehot_err_nxt || w_seq_err_nxt) && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
`ifdef RING_HOLD_LOCK_EN
      r_miss        <= w_miss_nxt;
`endif
    end
  end

  assign rif.index_out   = r_index;
  assign rif.index_valid = r_index_valid;
  assign rif.locked      = r_locked;
  assign rif.onehot_err  = r_onehot_err;
  assign rif.seq_err     = r_seq_err;
  assign rif.err_count   = r_err_count;

endmodule

// File: tb/tb_ring_decoder_checker.sv
// Directed bench for ring_decoder_checker (WIDTH=4, LOCK_CNT=3).
// Observed word per sample: {index_out[1:0], index_valid, locked, onehot_err, seq_err, err_count[7:0]}.
module tb_ring_decoder_checker;

`ifdef RING_HOLD_LOCK_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  ring_decoder_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) rif ();
  ring_decoder_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) rif2 ();

  ring_decoder_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .rif   (rif)
  );

  ring_decoder_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(2)) dut_sat (
    .clock (clock),
    .reset (reset),
    .rif   (rif2)
  );

  logic [13:0] obs;
  assign obs = {rif.index_out, rif.index_valid, rif.locked, rif.onehot_err,
                rif.seq_err, rif.err_count};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present one sample, then look at the registered result 1 ns after the edge.
  task automatic drive(input logic [3:0] w, input logic v);
    @(negedge clock);
    rif.ring_in    = w;
    rif.ring_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    rif.ring_in     = 4'b0001;
    rif.ring_valid  = 1'b1;
    rif2.ring_in    = 4'b0000;
    rif2.ring_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    if (obs !== 14'h0) begin
      $display("FAIL reset_outputs got %h want %h", obs, 14'h0);
      n_err++;
    end
    n_vec++;
    if (rif2.err_count !== 2'd0 || rif2.locked !== 1'b0) begin
      $display("FAIL reset_sat_outputs got cnt=%0d lck=%b want 0 0", rif2.err_count, rif2.locked);
      n_err++;
    end
    n_vec++;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    if (obs !== {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL reset_first_sample got %h want %h", obs, {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_rotate();
    logic [3:0]  w [5];
    logic [13:0] e [5];
    w = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    e = '{{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
          {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}};
    for (int k = 0; k < 5; k++) begin
      drive(w[k], 1'b1);
      if (obs !== e[k]) begin
        $display("FAIL rotate[%0d] got %h want %h", k, obs, e[k]);
        n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_seq_err();
    logic [3:0]  w [4];
    logic [13:0] e [4];
    w = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    e = '{{2'd2, 1'b1, HOLD, 1'b0, 1'b1, 8'd1},
          {2'd3, 1'b1, HOLD, 1'b0, 1'b0, 8'd1},
          {2'd0, 1'b1, HOLD, 1'b0, 1'b0, 8'd1},
          {2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}};
    for (int k = 0; k < 4; k++) begin
      drive(w[k], 1'b1);
      if (obs !== e[k]) begin
        $display("FAIL seq_err[%0d] got %h want %h", k, obs, e[k]);
        n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_onehot();
    logic [3:0]  w [6];
    logic [13:0] e [6];
    w = '{4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    e = '{{2'd1, 1'b0, HOLD, 1'b1, 1'b0, 8'd2},
          {2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3},
          {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3},
          {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3},
          {2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3},
          {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3}};
    for (int k = 0; k < 6; k++) begin
      drive(w[k], 1'b1);
      if (obs !== e[k]) begin
        $display("FAIL onehot[%0d] got %h want %h", k, obs, e[k]);
        n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    rif.ring_valid = 1'b0;
    @(posedge clock);
    #3;
    if (rif.locked !== 1'b1 || rif.err_count !== 8'd3) begin
      $display("FAIL async_pre got lck=%b cnt=%0d want 1 3", rif.locked, rif.err_count);
      n_err++;
    end
    n_vec++;
    reset = 1'b0;
    #1;
    if (obs !== 14'h0) begin
      $display("FAIL async_clear got %h want %h", obs, 14'h0);
      n_err++;
    end
    n_vec++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_gaps();
    logic [3:0]  w [10];
    logic        v [10];
    logic [13:0] e [10];
    w = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    e = '{{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
          {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
          {2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
          {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
          {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}};
    for (int k = 0; k < 10; k++) begin
      drive(w[k], v[k]);
      if (obs !== e[k]) begin
        $display("FAIL gaps[%0d] got %h want %h", k, obs, e[k]);
        n_err++;
      end
      n_vec++;
    end
  endtask

  task automatic test_saturate();
    logic [3:0] w [5];
    logic [1:0] e [5];
    w = '{4'b0000, 4'b0011, 4'b1111, 4'b0101, 4'b0000};
    e = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      rif2.ring_in    = w[k];
      rif2.ring_valid = 1'b1;
      @(posedge clock);
      #1;
      if (rif2.err_count !== e[k] || rif2.onehot_err !== 1'b1) begin
        $display("FAIL saturate[%0d] got cnt=%0d oh=%b want cnt=%0d oh=1",
                 k, rif2.err_count, rif2.onehot_err, e[k]);
        n_err++;
      end
      n_vec++;
    end
    @(negedge clock);
    rif2.ring_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_rotate();
    test_seq_err();
    test_onehot();
    test_async_reset();
    test_gaps();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ring_decoder_checker.md
Name: ring_decoder_checker

Overview:
Receive side of the one-hot ring counter interface. Samples a WIDTH-bit one-hot ring word, decodes it to a binary index and checks that successive words follow the ring rotation order. Declares lock after a run of correct transitions, flags illegal words and out-of-sequence words, and counts errors. Sits downstream of ring_counter instances as a sequence monitor and decoder.

Parameters:
WIDTH, 4, ring width in bits (≥2); index width IW = $clog2(WIDTH)
LOCK_CNT, 3, consecutive correct transitions required to assert lock (≥1)
ERR_CNT_W, 8, error counter width

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low
ring_in  input  WIDTH  ring word; bit i set means position i
ring_valid  input  1  ring_in is sampled on this edge
index_out  output  IW  decoded position of the last legal sample
index_valid  output  1  one-cycle pulse: index_out updated
locked  output  1  sequence lock established
onehot_err  output  1  one-cycle pulse: sampled word not one-hot
seq_err  output  1  one-cycle pulse: legal word, wrong position while LOCKED
err_count  output  ERR_CNT_W  saturating count of onehot_err plus seq_err events

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state UNLOCKED; expected index 0; match count 0. Release is synchronous to the next edge.
- Legal word: exactly one bit set. 0 and multi-bit words are illegal.
- Rotation order: position i is followed by (i+1) mod WIDTH, so 1000→0001 is correct for WIDTH=4.
- ring_valid=0: no state change; all pulse outputs 0 next cycle. Gaps do not affect lock.
- Latency: every output is registered and reflects the sample taken on the previous edge (1 cycle).
- Legal sample: index_out ← position; index_valid=1; expected ← (position+1) mod WIDTH.
- Illegal sample: index_out holds; index_valid=0; onehot_err=1; err_count increments.
- States:
  - UNLOCKED: a legal sample moves to LOCKING with match=0. An illegal sample stays in UNLOCKED.
  - LOCKING:
    - Legal and equal to expected: match+1. When match reaches LOCK_CNT, go to LOCKED.
    - Legal but not expected: match=0, adopt the new position, stay in LOCKING. No seq_err.
    - Illegal: go to UNLOCKED.
  - LOCKED:
    - Legal and expected: stay.
    - Legal but not expected: seq_err=1, err_count increments, go to LOCKING with match=0, adopt the new position.
    - Illegal: go to UNLOCKED.
- locked=1 exactly while the state is LOCKED, registered with the state.
- onehot_err and seq_err are mutually exclusive per sample. err_count increments by at most 1 per cycle and saturates at all-ones.
- Reset asserted mid-operation: immediate return to reset values, including err_count.

Optional Feature:
RING_HOLD_LOCK_EN
- Defined: LOCKED tolerates one isolated error. The first seq_err or onehot_err still pulses and is counted, but locked stays 1. On a legal error, expected is re-anchored to the received position + 1. A second consecutive erroneous sample drops to UNLOCKED (illegal word) or LOCKING (legal word). A correct sample clears the miss flag.
- Undefined: behaviour exactly as above; any error leaves LOCKED on the same edge.

Decomposition:
- Package ring_pkg:
  - state enum {UNLOCKED, LOCKING, LOCKED}
  - default WIDTH / LOCK_CNT constants
  - function for next index mod WIDTH
- Sub-module onehot_to_index: combinational, WIDTH in, index plus legal flag out. Reusable by other ring consumers.

Test Plan:
All scenarios use WIDTH=4, LOCK_CNT=3.
1. Hold reset low for 5 cycles with ring_in=0001, ring_valid=1 → all outputs 0, err_count=0. After release, the first sample gives index_out=0, index_valid=1.
2. Feed 0001, 0010, 0100, 1000, 0001 on consecutive cycles → index_out 0, 1, 2, 3, 0, each one cycle later. locked rises one cycle after the 1000 sample and stays high. No error pulses.
3. While LOCKED (last sample 0001), feed 0100 → seq_err pulse, err_count=1, locked=0, index_out=2. Then 1000, 0001, 0010 → locked re-asserts after 0010.
4. Feed 0110, then 0000 → two onehot_err pulses, index_valid=0, index_out unchanged, err_count +2, state UNLOCKED. Under RING_HOLD_LOCK_EN starting from LOCKED: locked stays 1 after 0110 and drops after 0000.
5. Assert reset asynchronously mid-LOCKED between edges → outputs clear immediately, before the next edge.
6. With ERR_CNT_W=2, feed 5 illegal words → err_count stops at 3. Separately, ring_valid gaps inside a correct sequence keep locked=1.
